// File: rtl/alu_arbiter_if.sv
// Bundle between the two ALU requesters, the arbiter, and the shared ALU.
// req is a level that is held until rsp_valid[i] is seen; rsp_valid is a one-cycle strobe.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req;
    logic [WIDTH-1:0] op_a0;
    logic [WIDTH-1:0] op_b0;
    logic [2:0]       ctrl0;
    logic [WIDTH-1:0] op_a1;
    logic [WIDTH-1:0] op_b1;
    logic [2:0]       ctrl1;
    logic [1:0]       gnt;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic             busy;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic [1:0]       state;

    modport master (
        output req, op_a0, op_b0, ctrl0, op_a1, op_b1, ctrl1, alu_result, alu_zero,
        input  gnt, rsp_valid, rsp_result, rsp_zero, rsp_err, busy,
               alu_a, alu_b, alu_control, state
    );

    modport slave (
        input  req, op_a0, op_b0, ctrl0, op_a1, op_b1, ctrl1, alu_result, alu_zero,
        output gnt, rsp_valid, rsp_result, rsp_zero, rsp_err, busy,
               alu_a, alu_b, alu_control, state
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one MIPS ALU between two requesters:
// grant in IDLE, capture the ALU result in EXEC, strobe the response in DONE.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;
    localparam logic [2:0] CTRL_ADD = 3'b010;

    logic [1:0]       state;
    logic             last;
    logic             illegal_q;
    logic             win;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_ctrl;
    logic             sel_illegal;

    // With both requests present the one not served last wins.
    always_comb begin
        win = 1'b0;
        case (bus.req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
        sel_a       = win ? bus.op_a1 : bus.op_a0;
        sel_b       = win ? bus.op_b1 : bus.op_b0;
        sel_ctrl    = win ? bus.ctrl1 : bus.ctrl0;
        sel_illegal = (sel_ctrl[2:1] == 2'b10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last            <= 1'b1;
            illegal_q       <= 1'b0;
            bus.gnt         <= 2'b00;
            bus.rsp_valid   <= 2'b00;
            bus.rsp_result  <= '0;
            bus.rsp_zero    <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_control <= CTRL_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        bus.alu_a       <= sel_a;
                        bus.alu_b       <= sel_b;
                        bus.alu_control <= sel_illegal ? CTRL_ADD : sel_ctrl;
                        illegal_q       <= sel_illegal;
                        bus.gnt         <= win ? 2'b10 : 2'b01;
                        last            <= win;
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    // An illegal op still occupies the ALU slot but reports a zeroed result.
                    bus.rsp_result <= illegal_q ? '0 : bus.alu_result;
                    bus.rsp_zero   <= illegal_q ? 1'b0 : bus.alu_zero;
                    bus.rsp_err    <= illegal_q;
                    bus.rsp_valid  <= bus.gnt;
                    bus.gnt        <= 2'b00;
                    state          <= DONE;
                end
                DONE: begin
                    bus.rsp_valid <= 2'b00;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.state = state;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 32-bit MIPS ALU between two requesters, for example the execute stage and the branch/address unit. It latches the winning requester's operands and ALU control code into registers that drive the ALU's `a`, `b` and `alu_control` inputs. It then captures the ALU `result`/`zero` outputs and returns them to the granted requester with a one-cycle response strobe. Illegal control codes are rejected with an error flag instead of being issued.

## Interface
- `WIDTH`, 32, operand/result width; must match the ALU.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-requester request level; bit i = requester i.
- `op_a0`, `op_b0`  in  WIDTH  requester 0 operands.
- `ctrl0`  in  3  requester 0 ALU control code.
- `op_a1`, `op_b1`  in  WIDTH  requester 1 operands.
- `ctrl1`  in  3  requester 1 ALU control code.
- `gnt`  out  2  one-hot grant, high during EXEC for the served requester.
- `rsp_valid`  out  2  one-hot response strobe, high for exactly one cycle (DONE).
- `rsp_result`  out  WIDTH  registered result, shared by both requesters.
- `rsp_zero`  out  1  registered zero flag.
- `rsp_err`  out  1  registered illegal-op flag.
- `busy`  out  1  high whenever state != IDLE.
- `alu_a`, `alu_b`  out  WIDTH  registered drive to the ALU operands.
- `alu_control`  out  3  registered drive to the ALU control input.
- `alu_result`  in  WIDTH  ALU result, combinational from `alu_*`.
- `alu_zero`  in  1  ALU zero flag.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - If `req` != 0, select the winner.
  - Latch its operands/ctrl into `alu_a`/`alu_b`/`alu_control`.
  - Set `gnt[winner]`, update `last`, go to EXEC.
  - Otherwise stay in IDLE.
- Arbitration:
  - If only one request is present, that requester wins.
  - If both are present, the winner is the requester != `last`.
  - `last` resets to 1, so requester 0 wins the first contention.
- EXEC:
  - Capture `alu_result` → `rsp_result` and `alu_zero` → `rsp_zero`.
  - Set `rsp_valid[winner]`, clear `gnt`, go to DONE.
- Legal ctrl codes: 010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt (unsigned compare).
- Illegal ctrl codes (100, 101):
  - Latch `alu_control` = 010 instead.
  - In EXEC force `rsp_result` = 0, `rsp_zero` = 0, `rsp_err` = 1.
  - `rsp_err` = 0 for legal ops.
- DONE:
  - Clear `rsp_valid`, go to IDLE.
  - `req` is ignored in this cycle.
- `rsp_result`/`rsp_zero`/`rsp_err` hold their values until the next EXEC capture.
- `alu_*` hold their values until the next grant.
- Requester contract:
  - Hold `req` and operands stable from assertion until the cycle `rsp_valid[i]` is seen.
  - Drop `req` or present the next op on that edge.
  - Operand changes while not granted are harmless. They are sampled only at the IDLE grant edge.
- Reset values:
  - State IDLE, `last` = 1.
  - `gnt`, `rsp_valid` = 0.
  - `rsp_result` = 0, `rsp_zero` = 0, `rsp_err` = 0.
  - `alu_a` = `alu_b` = 0, `alu_control` = 010.
  - `busy` = 0.
- Reset mid-operation aborts the operation: no `rsp_valid` is issued, and the requester must re-request.

## Timing
- Let edge k be the edge at which `req[i]` is sampled high in IDLE.
- After edge k: EXEC, `gnt[i]` = 1, `alu_*` valid. The ALU settles combinationally within this cycle.
- After edge k+1: DONE, `rsp_valid[i]` = 1, response fields valid.
- After edge k+2: IDLE.
- Latency: 2 cycles from the sampling edge to `rsp_valid`.
- Throughput: one operation per 3 cycles.
- Back-to-back contention alternates 0,1,0,1…
- A lone requester with `req` held high is served every 3 cycles.
- `busy` is high for the EXEC and DONE cycles.
- No combinational path from `req` to any output. All outputs are registered.

## Test plan
- Reset then idle: all outputs hold their reset values; `req` = 00 for 10 cycles → `busy` stays 0.
- Single add:
  - Stimulus: `req` = 01, `op_a0` = 5, `op_b0` = 7, `ctrl0` = 010 at edge k.
  - Required: `gnt` = 01 after edge k; `rsp_valid` = 01 after k+1 with `rsp_result` = 12, `rsp_zero` = 0, `rsp_err` = 0.
- Zero and slt:
  - req1 sub 9−9 → `rsp_result` = 0, `rsp_zero` = 1.
  - req1 slt 3<8 → `rsp_result` = 1.
  - req1 slt 0xFFFFFFFF<1 → `rsp_result` = 0.
- Contention: both requesters hold `req` = 11 for 4 ops → grants 0,1,0,1, each `rsp_valid` 3 cycles apart, each result matching its own operands.
- Illegal op: `ctrl0` = 100 → `alu_control` = 010, `rsp_err` = 1, `rsp_result` = 0, `rsp_zero` = 0. The next legal op clears `rsp_err`.
- Reset mid-op:
  - Stimulus: assert `rst` during EXEC.
  - Required: `gnt`/`rsp_valid` go 0 immediately (asynchronous), no response after release, and the next contention grants requester 0.
